// File: rtl/mmio_peripherals.sv
// Memory-mapped LED, debounced button, button-edge and compare-timer registers on the Cpu data bus.
// Defining MMIO_TIMER_EN builds the TIMER/CMP/STATUS registers and irq; otherwise they read 0.
module mmio_peripherals #(
  parameter logic [31:0] BASE_ADDR       = 32'h8000_0000,
  parameter int unsigned LED_WIDTH       = 8,
  parameter int unsigned BTN_WIDTH       = 7,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          read_address,
  output logic [31:0]          read_data,
  output logic                 read_hit,
  input  logic [31:0]          write_address,
  input  logic [31:0]          write_data,
  input  logic [3:0]           write_enable,
  input  logic [BTN_WIDTH-1:0] btn,
  output logic [LED_WIDTH-1:0] led,
  output logic                 irq
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  localparam logic [7:0] OffLed    = 8'h00;
  localparam logic [7:0] OffBtn    = 8'h04;
  localparam logic [7:0] OffEdge   = 8'h08;
  localparam logic [7:0] OffTimer  = 8'h0C;
  localparam logic [7:0] OffCmp    = 8'h10;
  localparam logic [7:0] OffStatus = 8'h14;

  function automatic logic [31:0] byte_mask(input logic [3:0] be);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{be[i]}};
    end
    return m;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] m;
    m = byte_mask(be);
    return (old & ~m) | (data & m);
  endfunction

  // Write decode
  logic        wr_hit;
  logic [7:0]  wr_off;
  logic [31:0] wr_mask;

  assign wr_hit  = (write_enable != 4'b0) && (write_address[31:8] == BASE_ADDR[31:8]);
  assign wr_off  = write_address[7:0];
  assign wr_mask = byte_mask(write_enable);

  // LED register
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic [31:0]          led_merged;

  always_comb begin
    led_merged = merge(32'(led_q), write_data, write_enable);
    led_d      = led_q;
    if (wr_hit && wr_off == OffLed) begin
      led_d = led_merged[LED_WIDTH-1:0];
    end
  end

  // Button synchronizers and per-bit debounce counters
  logic [BTN_WIDTH-1:0] sync1_q, sync2_q, stable_q, stable_d;
  logic [CntW-1:0]      cnt_q [BTN_WIDTH];
  logic [CntW-1:0]      cnt_d [BTN_WIDTH];

  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < BTN_WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CntLast) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Rising-edge latch; a new edge wins over a simultaneous clear
  logic [BTN_WIDTH-1:0] edge_q, edge_d, edge_clr;

  always_comb begin
    edge_clr = '0;
    if (wr_hit && wr_off == OffEdge) begin
      edge_clr = write_data[BTN_WIDTH-1:0] & wr_mask[BTN_WIDTH-1:0];
    end
    edge_d = (edge_q & ~edge_clr) | (stable_d & ~stable_q);
  end

`ifdef MMIO_TIMER_EN
  logic [31:0] timer_q, timer_d, cmp_q, cmp_d;
  logic        status_q, status_d;

  always_comb begin
    timer_d  = timer_q + 32'd1;
    cmp_d    = cmp_q;
    status_d = status_q;
    if (wr_hit && wr_off == OffTimer) begin
      timer_d = merge(timer_q, write_data, write_enable);
    end
    if (wr_hit && wr_off == OffCmp) begin
      cmp_d = merge(cmp_q, write_data, write_enable);
    end
    if (wr_hit && wr_off == OffStatus && write_enable[0] && write_data[0]) begin
      status_d = 1'b0;
    end
    if (timer_q == cmp_q) begin
      status_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q  <= '0;
      cmp_q    <= 32'hFFFF_FFFF;
      status_q <= 1'b0;
    end else begin
      timer_q  <= timer_d;
      cmp_q    <= cmp_d;
      status_q <= status_d;
    end
  end

  assign irq = status_q;
`else
  assign irq = 1'b0;
`endif

  // Read path: registered, so a same-cycle write is seen only on the next read
  logic        rd_hit;
  logic [31:0] rd_data;
  logic [31:0] read_data_q;
  logic        read_hit_q;

  always_comb begin
    rd_hit  = (read_address[31:8] == BASE_ADDR[31:8]);
    rd_data = '0;
    if (rd_hit) begin
      case (read_address[7:0])
        OffLed:    rd_data = 32'(led_q);
        OffBtn:    rd_data = 32'(stable_q);
        OffEdge:   rd_data = 32'(edge_q);
`ifdef MMIO_TIMER_EN
        OffTimer:  rd_data = timer_q;
        OffCmp:    rd_data = cmp_q;
        OffStatus: rd_data = {31'b0, status_q};
`endif
        default:   rd_data = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      led_q       <= '0;
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      edge_q      <= '0;
      read_data_q <= '0;
      read_hit_q  <= 1'b0;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      led_q       <= led_d;
      sync1_q     <= btn;
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      edge_q      <= edge_d;
      read_data_q <= rd_data;
      read_hit_q  <= rd_hit;
      for (int i = 0; i < BTN_WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign led       = led_q;
  assign read_data = read_data_q;
  assign read_hit  = read_hit_q;

endmodule

// File: tb/tb_mmio_peripherals.sv
// Scoreboard bench for mmio_peripherals: expected reads are queued when issued and checked on return.
module tb_mmio_peripherals;

  localparam logic [31:0] A_LED = 32'h8000_0000;
  localparam logic [31:0] A_BTN = 32'h8000_0004;
  localparam logic [31:0] A_EDG = 32'h8000_0008;
  localparam logic [31:0] A_TMR = 32'h8000_000C;
  localparam logic [31:0] A_CMP = 32'h8000_0010;
  localparam logic [31:0] A_STS = 32'h8000_0014;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] read_address = '0;
  logic [31:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic [3:0]  write_enable = '0;
  logic [6:0]  btn = '0;
  logic [31:0] read_data;
  logic        read_hit;
  logic [7:0]  led;
  logic        irq;

  mmio_peripherals #(
    .BASE_ADDR      (32'h8000_0000),
    .LED_WIDTH      (8),
    .BTN_WIDTH      (7),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .read_address (read_address),
    .read_data    (read_data),
    .read_hit     (read_hit),
    .write_address(write_address),
    .write_data   (write_data),
    .write_enable (write_enable),
    .btn          (btn),
    .led          (led),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  typedef struct {
    int          due;
    logic        hit;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Read returns are sampled 1ns after the edge that captured them
  always @(posedge clock) begin
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      mon_e = sb.pop_front();
      check_val({mon_e.tag, "_hit"}, 32'(read_hit), 32'(mon_e.hit));
      check_val(mon_e.tag, read_data, mon_e.data);
    end
  end

  task automatic expect_rd(input string tag, input logic h, input logic [31:0] d);
    exp_t e;
    e.due  = cyc + 1;
    e.hit  = h;
    e.data = d;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  // All tasks start and end just after a falling edge
  task automatic rd(input string tag, input logic [31:0] a, input logic h, input logic [31:0] d);
    read_address = a;
    expect_rd(tag, h, d);
    @(negedge clock);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we);
    write_address = a;
    write_data    = d;
    write_enable  = we;
    @(negedge clock);
    write_enable  = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_val("rst_led", 32'(led), 32'h0);
    check_val("rst_irq", 32'(irq), 32'h0);
    check_val("rst_hit", 32'(read_hit), 32'h0);
    check_val("rst_data", read_data, 32'h0);
`ifdef MMIO_TIMER_EN
    rd("rst_cmp", A_CMP, 1'b1, 32'hFFFF_FFFF);
`endif

    // LED write/read, decode
    wr(A_LED, 32'h0000_00A5, 4'b0001);
    check_val("led_out", 32'(led), 32'hA5);
    rd("led_rd", A_LED, 1'b1, 32'hA5);
    rd("miss", 32'h0000_0010, 1'b0, 32'h0);
    rd("unmapped", 32'h8000_0020, 1'b1, 32'h0);
    wr(A_LED, 32'h1234_56FF, 4'b0010);
    rd("led_mask", A_LED, 1'b1, 32'hA5);

    // Same-cycle read and write returns the old value
    read_address  = A_LED;
    write_address = A_LED;
    write_data    = 32'h0000_0011;
    write_enable  = 4'b1111;
    expect_rd("rw_same", 1'b1, 32'hA5);
    @(negedge clock);
    write_enable = '0;
    rd("rw_after", A_LED, 1'b1, 32'h11);

    // Debounce latency: level visible on the 7th read return after the change
    read_address = A_BTN;
    btn[0] = 1'b1;
    c0 = cyc;
    for (int k = 0; k < 9; k++) begin
      expect_rd($sformatf("btn_lat%0d", k), 1'b1, ((cyc + 1 - c0) >= 7) ? 32'h1 : 32'h0);
      @(negedge clock);
    end
    rd("edge_set", A_EDG, 1'b1, 32'h1);

    // Short glitch is filtered
    btn[1] = 1'b1;
    repeat (3) @(negedge clock);
    btn[1] = 1'b0;
    repeat (8) @(negedge clock);
    rd("glitch_btn", A_BTN, 1'b1, 32'h1);
    rd("glitch_edge", A_EDG, 1'b1, 32'h1);

    // Rising edge coinciding with a W1C keeps the bit set
    btn[0] = 1'b0;
    repeat (8) @(negedge clock);
    rd("fall_btn", A_BTN, 1'b1, 32'h0);
    rd("fall_edge", A_EDG, 1'b1, 32'h1);
    btn[0] = 1'b1;
    repeat (5) @(negedge clock);
    wr(A_EDG, 32'h1, 4'b1111);
    rd("edge_setwins", A_EDG, 1'b1, 32'h1);
    rd("rise_btn", A_BTN, 1'b1, 32'h1);
    wr(A_EDG, 32'h1, 4'b1111);
    rd("edge_w1c", A_EDG, 1'b1, 32'h0);

`ifdef MMIO_TIMER_EN
    // Compare interrupt
    wr(A_CMP, 32'd10, 4'b1111);
    rd("cmp_rd", A_CMP, 1'b1, 32'd10);
    wr(A_TMR, 32'd0, 4'b1111);
    repeat (10) @(negedge clock);
    check_val("irq_early", 32'(irq), 32'h0);
    @(negedge clock);
    check_val("irq_match", 32'(irq), 32'h1);
    rd("sts_rd", A_STS, 1'b1, 32'h1);
    wr(A_STS, 32'h1, 4'b0001);
    check_val("irq_w1c", 32'(irq), 32'h0);
    wr(A_TMR, 32'hFFFF_FFF0, 4'b1111);
    repeat (26) @(negedge clock);
    check_val("irq_prewrap", 32'(irq), 32'h0);
    @(negedge clock);
    check_val("irq_wrap", 32'(irq), 32'h1);

    // Byte write while counting replaces byte1 and skips that increment
    wr(A_TMR, 32'h1234_5678, 4'b1111);
    repeat (3) @(negedge clock);
    wr(A_TMR, 32'h0000_AB00, 4'b0010);
    rd("tmr_byte", A_TMR, 1'b1, 32'h1234_AB7B);
    check_val("irq_pre_rst", 32'(irq), 32'h1);
`else
    rd("nt_tmr", A_TMR, 1'b1, 32'h0);
    wr(A_TMR, 32'h0000_0005, 4'b1111);
    wr(A_CMP, 32'h0000_0005, 4'b1111);
    rd("nt_tmr_wr", A_TMR, 1'b1, 32'h0);
    rd("nt_cmp", A_CMP, 1'b1, 32'h0);
    rd("nt_sts", A_STS, 1'b1, 32'h0);
    check_val("nt_irq", 32'(irq), 32'h0);
`endif

    // Reset mid-debounce with a pending write
    wr(A_LED, 32'h0000_00FF, 4'b1111);
    check_val("led_ff", 32'(led), 32'hFF);
    btn[2] = 1'b1;
    repeat (3) @(negedge clock);
    read_address  = A_LED;
    reset         = 1'b1;
    write_address = A_LED;
    write_data    = 32'h0000_003C;
    write_enable  = 4'b1111;
    @(negedge clock);
    reset        = 1'b0;
    write_enable = '0;
    check_val("rst2_led", 32'(led), 32'h0);
    check_val("rst2_hit", 32'(read_hit), 32'h0);
    check_val("rst2_data", read_data, 32'h0);
    check_val("rst2_irq", 32'(irq), 32'h0);
`ifdef MMIO_TIMER_EN
    rd("rst2_tmr", A_TMR, 1'b1, 32'h0);
    rd("rst2_cmp", A_CMP, 1'b1, 32'hFFFF_FFFF);
    rd("rst2_sts", A_STS, 1'b1, 32'h0);
`else
    rd("rst2_tmr", A_TMR, 1'b1, 32'h0);
`endif
    rd("rst2_btn", A_BTN, 1'b1, 32'h0);
    rd("rst2_edge", A_EDG, 1'b1, 32'h0);

    repeat (2) @(negedge clock);
    check_val("sb_empty", 32'(sb.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
